// File: rtl/fsk_tx_scheduler.sv
// Frames bytes as start/8 data (LSB first)/stop FSK bits and drives the tone divider's half-period count.
// Optional macro FSK_PHASE_SYNC_EN: new counts reach div_c only on a rising edge of the fed-back tone_clk.

module fsk_tx_scheduler #(
    parameter int unsigned BIT_CYCLES = 5000,
    parameter logic [31:0] C_MARK     = 32'd1249,
    parameter logic [31:0] C_SPACE    = 32'd2499
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic        tone_clk,
    output logic [31:0] div_c,
    output logic        bit_out,
    output logic        busy
);

    localparam int unsigned      CNT_W    = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 32'd1);

    generate
        if (BIT_CYCLES < 2) begin : g_bad_bit_cycles
            $error("fsk_tx_scheduler: BIT_CYCLES must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_ready_q, tx_ready_d;
    logic             busy_q, busy_d;
    logic             bit_out_q, bit_out_d;
    logic [31:0]      div_c_q, div_c_d;
    logic             tone_prev_q, tone_prev_d;
    logic [31:0]      pending_q, pending_d;
    logic [31:0]      target_s;
    logic             accept_s;
    logic             bit_end_s;
    logic             unused_s;

    function automatic logic [31:0] c_for_bit(input logic b);
        if (b) begin
            return C_MARK;
        end else begin
            return C_SPACE;
        end
    endfunction

    assign accept_s  = (state_q == ST_IDLE) && tx_valid && tx_ready_q;
    assign bit_end_s = (bit_cnt_q == CNT_LAST);
    // Only meaningful in the phase-sync build; keeps every input and register referenced.
    assign unused_s  = ^{tone_clk, tone_prev_q, pending_q};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every bit lasts exactly BIT_CYCLES clocks.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_START;
                else          state_d = ST_IDLE;
            end
            ST_START: begin
                if (bit_end_s) state_d = ST_DATA;
                else           state_d = ST_START;
            end
            ST_DATA: begin
                if (bit_end_s && (bit_idx_q == 3'd7)) state_d = ST_STOP;
                else                                 state_d = ST_DATA;
            end
            ST_STOP: begin
                if (bit_end_s) state_d = ST_IDLE;
                else           state_d = ST_STOP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; outputs follow the next state so they change on the transition edge.
    always_comb begin
        if (state_q == ST_IDLE) begin
            bit_cnt_d = {CNT_W{1'b0}};
        end else if (bit_end_s) begin
            bit_cnt_d = {CNT_W{1'b0}};
        end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1'b1);
        end

        if ((state_q == ST_DATA) && bit_end_s) begin
            bit_idx_d = bit_idx_q + 3'd1;
        end else if (state_q == ST_DATA) begin
            bit_idx_d = bit_idx_q;
        end else begin
            bit_idx_d = 3'd0;
        end

        if (accept_s) begin
            shift_d = tx_data;
        end else if ((state_q == ST_DATA) && bit_end_s) begin
            shift_d = {1'b0, shift_q[7:1]};
        end else begin
            shift_d = shift_q;
        end

        case (state_d)
            ST_IDLE:  bit_out_d = 1'b1;
            ST_START: bit_out_d = 1'b0;
            ST_DATA:  bit_out_d = shift_d[0];
            ST_STOP:  bit_out_d = 1'b1;
            default:  bit_out_d = 1'b1;
        endcase

        tx_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
        target_s   = c_for_bit(bit_out_d);
        pending_d  = target_s;
`ifdef FSK_PHASE_SYNC_EN
        tone_prev_d = tone_clk;
        if (tone_clk && !tone_prev_q) begin
            div_c_d = pending_q;
        end else begin
            div_c_d = div_c_q;
        end
`else
        tone_prev_d = 1'b0;
        div_c_d     = target_s;
`endif
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q   <= {CNT_W{1'b0}};
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            tx_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            bit_out_q   <= 1'b1;
            div_c_q     <= C_MARK;
            tone_prev_q <= 1'b0;
            pending_q   <= C_MARK;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            tx_ready_q  <= tx_ready_d;
            busy_q      <= busy_d;
            bit_out_q   <= bit_out_d;
            div_c_q     <= div_c_d;
            tone_prev_q <= tone_prev_d;
            pending_q   <= pending_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign bit_out  = bit_out_q;
    assign div_c    = div_c_q;

endmodule
